store_size_unit: RTL and testbench

Store-path counterpart of the load-side sign/zero extender. It takes a 32-bit register value and a store type (SW/SH/SB) and writes the correct word, halfword or byte into word-addressed data memory. Word stores are written directly. Sub-word stores do a read-modify-write: read the word, merge the selected lane, write it back. It sits between the datapath (rt value and ALU address) and the data memory port, and is driven by the control FSM via a start/done handshake.

---
 rtl/store_size_unit_pkg.sv | 34 +++
 rtl/store_lane_merge.sv | 38 +++
 rtl/store_size_unit.sv | 146 ++++++++++++++
 tb/tb_store_size_unit.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/store_size_unit_pkg.sv
// Shared definitions for the store size unit: store type codes, FSM state
// encodings, READ_LATENCY limits and the alignment rule.
package store_size_unit_pkg;

    typedef enum logic [1:0] {
        ST_SW  = 2'b00,
        ST_SH  = 2'b01,
        ST_SB  = 2'b10,
        ST_RSV = 2'b11
    } store_type_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    localparam int READ_LATENCY_MIN = 1;
    localparam int READ_LATENCY_MAX = 4;

    // A word store needs addr[1:0] == 0, a halfword store needs addr[0] == 0.
    function automatic logic is_misaligned(input logic [1:0] st, input logic [1:0] lo);
        logic mis;
        case (st)
            ST_SW:   mis = (lo != 2'b00);
            ST_SH:   mis = lo[0];
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational lane merge: places the stored byte/halfword into the
// little-endian lane of the read word, or passes the full word for SW.
module store_lane_merge
    import store_size_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [31:0] data,
    input  logic [1:0]  store_type,
    input  logic [1:0]  addr_lo,
    output logic [31:0] merged
);

    // Replace only the addressed lane; reserved codes leave the word untouched.
    always_comb begin
        merged = rdata;
        case (store_type)
            ST_SW: merged = data;
            ST_SH: begin
                if (addr_lo[1]) begin
                    merged[31:16] = data[15:0];
                end else begin
                    merged[15:0] = data[15:0];
                end
            end
            ST_SB: begin
                case (addr_lo)
                    2'd0:    merged[7:0]   = data[7:0];
                    2'd1:    merged[15:8]  = data[7:0];
                    2'd2:    merged[23:16] = data[7:0];
                    2'd3:    merged[31:24] = data[7:0];
                    default: merged = rdata;
                endcase
            end
            default: merged = rdata;
        endcase
    end

endmodule

// File: rtl/store_size_unit.sv
// Store size unit: writes SW/SH/SB stores into word-addressed memory.
// Word stores write directly; sub-word stores read, merge and write back.
// Optional build macro STORE_ALIGN_CHECK_EN: when defined, misaligned SW/SH
// requests skip memory access and pulse align_err together with done.
module store_size_unit
    import store_size_unit_pkg::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  store_type,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        align_err
);

    // Final WAIT count value; the counter runs 0 .. READ_LATENCY-1.
    localparam logic [1:0] CNT_LAST = 2'(READ_LATENCY - 1);

    state_e      state_r;
    state_e      state_s;
    logic [1:0]  cnt_r;
    logic [1:0]  store_type_q;
    logic [31:0] addr_q;
    logic [31:0] data_in_q;
    logic [31:0] rdata_q;
    logic [31:0] merged_s;
    logic        misalign_s;
    logic        mem_rd_r;
    logic        mem_wr_r;
    logic        done_r;
    logic        busy_r;
    logic        align_err_r;

    // Alignment check on the live request, only meaningful in IDLE with start.
    always_comb begin
`ifdef STORE_ALIGN_CHECK_EN
        misalign_s = is_misaligned(store_type, addr[1:0]);
`else
        misalign_s = 1'b0;
`endif
    end

    // Next-state decode for the store sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    if ((store_type == ST_RSV) || misalign_s) begin
                        state_s = S_DONE;
                    end else if (store_type == ST_SW) begin
                        state_s = S_WRITE;
                    end else begin
                        state_s = S_READ;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_READ:  state_s = S_WAIT;
            S_WAIT: begin
                if (cnt_r == CNT_LAST) begin
                    state_s = S_WRITE;
                end else begin
                    state_s = S_WAIT;
                end
            end
            S_WRITE: state_s = S_DONE;
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // State register and registered strobes decoded from the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= S_IDLE;
            mem_rd_r    <= 1'b0;
            mem_wr_r    <= 1'b0;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
            align_err_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            mem_rd_r    <= (state_s == S_READ);
            mem_wr_r    <= (state_s == S_WRITE);
            done_r      <= (state_s == S_DONE);
            busy_r      <= (state_s != S_IDLE);
            align_err_r <= (state_r == S_IDLE) && start && misalign_s;
        end
    end

    // Request capture in IDLE, read-latency counter and read data capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r        <= 2'd0;
            store_type_q <= 2'b00;
            addr_q       <= 32'h0000_0000;
            data_in_q    <= 32'h0000_0000;
            rdata_q      <= 32'h0000_0000;
        end else begin
            if ((state_r == S_IDLE) && start) begin
                store_type_q <= store_type;
                addr_q       <= addr;
                data_in_q    <= data_in;
            end
            if (state_r == S_WAIT) begin
                if (cnt_r == CNT_LAST) begin
                    cnt_r   <= 2'd0;
                    rdata_q <= mem_rdata;
                end else begin
                    cnt_r <= cnt_r + 2'd1;
                end
            end else begin
                cnt_r <= 2'd0;
            end
        end
    end

    store_lane_merge u_merge (
        .rdata      (rdata_q),
        .data       (data_in_q),
        .store_type (store_type_q),
        .addr_lo    (addr_q[1:0]),
        .merged     (merged_s)
    );

    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_wdata = mem_wr_r ? merged_s : 32'h0000_0000;
    assign mem_rd    = mem_rd_r;
    assign mem_wr    = mem_wr_r;
    assign done      = done_r;
    assign busy      = busy_r;
    assign align_err = align_err_r;

endmodule

// File: tb/tb_store_size_unit.sv
// Self-checking bench for store_size_unit: a bench-side memory with read
// latency, a byte-arithmetic reference of the expected memory image, and
// per-request timing expectations derived from the store rules.
module tb_store_size_unit;

    localparam int RL = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [1:0]  store_type;
    logic [31:0] addr;
    logic [31:0] data_in;
    logic [31:0] mem_rdata;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        align_err;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem     [16];
    logic [31:0] exp_mem [16];
    logic [2:0]  rd_cnt;
    logic [3:0]  rd_idx;
    logic        pre_we;
    logic [3:0]  pre_idx;
    logic [31:0] pre_val;

    always #5 clk = ~clk;

    store_size_unit #(.READ_LATENCY(RL)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .store_type (store_type),
        .addr       (addr),
        .data_in    (data_in),
        .mem_rdata  (mem_rdata),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .align_err  (align_err)
    );

    // Memory array: preload port and write port.
    always @(posedge clk) begin
        if (pre_we) mem[pre_idx] <= pre_val;
        else if (mem_wr) mem[mem_addr[5:2]] <= mem_wdata;
    end

    // Read latency model: data valid exactly RL cycles after the mem_rd cycle.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_cnt <= 3'd0;
            rd_idx <= 4'd0;
        end else if (mem_rd) begin
            rd_cnt <= 3'(RL);
            rd_idx <= mem_addr[5:2];
        end else if (rd_cnt != 3'd0) begin
            rd_cnt <= rd_cnt - 3'd1;
        end
    end

    assign mem_rdata = (rd_cnt == 3'd1) ? mem[rd_idx] : 32'hA5A5_5A5A;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] val);
        @(negedge clk);
        pre_we  = 1'b1;
        pre_idx = 4'(idx);
        pre_val = val;
        @(negedge clk);
        pre_we  = 1'b0;
        exp_mem[idx] = val;
    endtask

    task automatic run_op(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d,
                          input bit extra_start);
        int idx = int'(a[5:2]);
        logic [31:0] neww = exp_mem[idx];
        int sh;
        bit mis = 1'b0;
        bit exp_rd = 1'b0;
        bit exp_wr = 1'b0;
        int exp_done;
        int rd_n = 0, wr_n = 0, done_n = 0, al_n = 0;
        int rd_cyc = 0, wr_cyc = 0, done_cyc = 0;
        logic [31:0] wr_data = 32'h0, wr_addr = 32'h0;
        bit ext;
`ifdef STORE_ALIGN_CHECK_EN
        mis = ((t == 2'd0) && (a[1:0] != 2'd0)) || ((t == 2'd1) && a[0]);
`endif
        if ((t == 2'd3) || mis) begin
            exp_done = 1;
        end else if (t == 2'd0) begin
            neww = d; exp_wr = 1'b1; exp_done = 2;
        end else if (t == 2'd1) begin
            sh = a[1] ? 16 : 0;
            neww = (neww & ~(32'hFFFF << sh)) | ((d & 32'hFFFF) << sh);
            exp_rd = 1'b1; exp_wr = 1'b1; exp_done = 3 + RL;
        end else begin
            sh = 8 * int'(a[1:0]);
            neww = (neww & ~(32'hFF << sh)) | ((d & 32'hFF) << sh);
            exp_rd = 1'b1; exp_wr = 1'b1; exp_done = 3 + RL;
        end
        ext = extra_start && (exp_done > 2);
        @(negedge clk);
        start = 1'b1; store_type = t; addr = a; data_in = d;
        @(posedge clk);
        #1;
        start = 1'b0; store_type = 2'($urandom); addr = $urandom; data_in = $urandom;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            if (ext && cyc == 2) begin
                start = 1'b1; store_type = 2'd0;
            end
            if (ext && cyc == 3) start = 1'b0;
            if (mem_rd) begin rd_n++; rd_cyc = cyc; end
            if (mem_wr) begin wr_n++; wr_cyc = cyc; wr_data = mem_wdata; wr_addr = mem_addr; end
            if (done) begin done_n++; done_cyc = cyc; end
            if (align_err) al_n++;
            if (cyc == 1) check("busy_c1", 32'(busy), 32'd1);
        end
        check("done_n", 32'(done_n), 32'd1);
        check("done_cyc", 32'(done_cyc), 32'(exp_done));
        check("rd_n", 32'(rd_n), 32'(exp_rd));
        check("wr_n", 32'(wr_n), 32'(exp_wr));
        check("align_n", 32'(al_n), 32'(mis));
        if (exp_rd) check("rd_cyc", 32'(rd_cyc), 32'd1);
        if (exp_wr) begin
            check("wr_cyc", 32'(wr_cyc), 32'(exp_done - 1));
            check("wr_addr", wr_addr, {a[31:2], 2'b00});
            check("wr_data", wr_data, neww);
        end
        check("busy_end", 32'(busy), 32'd0);
        check("mem_word", mem[idx], neww);
        exp_mem[idx] = neww;
    endtask

    initial begin
        int wr_seen;
        logic [1:0] t;
        reset_n = 1'b0; start = 1'b0; store_type = 2'd0; addr = 32'h0; data_in = 32'h0;
        pre_we = 1'b0; pre_idx = 4'd0; pre_val = 32'h0;
        for (int i = 0; i < 16; i++) preload(i, $urandom);
        preload(4, 32'h1122_3344);
        preload(5, 32'h1122_3344);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rd", 32'(mem_rd), 32'd0);
        check("rst_wr", 32'(mem_wr), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_align", 32'(align_err), 32'd0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);

        run_op(2'd2, 32'h0000_0013, 32'h0000_00AB, 1'b0);
        run_op(2'd1, 32'h0000_0016, 32'hFFFF_CAFE, 1'b0);
        run_op(2'd0, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
        run_op(2'd1, 32'h0000_0011, 32'h1234_5678, 1'b0);
        run_op(2'd0, 32'h0000_0023, 32'h8765_4321, 1'b0);
        run_op(2'd3, 32'h0000_0020, 32'h5555_AAAA, 1'b0);
        run_op(2'd2, 32'h0000_0030, 32'h0000_0077, 1'b1);

        // Reset pulled low in the WAIT cycle of a byte store.
        @(negedge clk);
        start = 1'b1; store_type = 2'd2; addr = 32'h0000_001B; data_in = 32'h0000_00EE;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_rd", 32'(mem_rd), 32'd0);
        check("arst_wr", 32'(mem_wr), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_addr", mem_addr, 32'h0);
        check("arst_wdata", mem_wdata, 32'h0);
        wr_seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (mem_wr) wr_seen++;
        end
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (mem_wr) wr_seen++;
        end
        check("arst_no_wr", 32'(wr_seen), 32'd0);
        check("arst_mem", mem[6], exp_mem[6]);
        run_op(2'd0, 32'h0000_0018, 32'hC0DE_F00D, 1'b0);

        for (int n = 0; n < 40; n++) begin
            t = 2'($urandom_range(0, 3));
            run_op(t, $urandom, $urandom, 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
